bus_memory_responder: RTL and testbench

- Memory-side responder for the 5-bit-address, 16-bit-line cache/memory bus.
- Serves line reads (fill) and line writes (write-back) from a 32 x 16-bit backing array.
- Handshake: level request held by the initiator until a one-cycle bus_done pulse.
- Sits opposite the cache controller, with programmable access latency; used as the system memory model and as the memory end in cache benches.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_array_32x16.sv | 42 ++++
 rtl/bus_memory_responder.sv | 156 +++++++++++++++
 tb/tb_bus_memory_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 5-bit-address / 16-bit-line cache-memory bus.
package mem_bus_pkg;

    localparam int BUS_ADDR_W = 5;
    localparam int BUS_DATA_W = 16;
    localparam int MEM_DEPTH  = 32;

    // One-hot responder states
    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_BUSY = 3'b010,
        R_DONE = 3'b100
    } resp_state_t;

    // Power-on content of a line: its own index in both bytes, optionally scrambled
    function automatic logic [BUS_DATA_W-1:0] reset_word(
        input logic [BUS_ADDR_W-1:0] idx,
        input logic [BUS_DATA_W-1:0] xor_mask
    );
        return {3'b000, idx, 3'b000, idx} ^ xor_mask;
    endfunction

endpackage

// File: rtl/mem_array_32x16.sv
// 32 x 16-bit backing store: async-reset preload, one write port and one
// registered read port.
module mem_array_32x16
    import mem_bus_pkg::*;
#(
    parameter logic [BUS_DATA_W-1:0] INIT_XOR = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [BUS_ADDR_W-1:0] addr,
    input  logic [BUS_DATA_W-1:0] wdata,
    output logic [BUS_DATA_W-1:0] rdata
);

    logic [BUS_DATA_W-1:0] mem_r [MEM_DEPTH];
    logic [BUS_DATA_W-1:0] rdata_r;

    // Storage: preload the index pattern on reset, otherwise take writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MEM_DEPTH; k++) begin
                mem_r[k] <= reset_word(BUS_ADDR_W'(k), INIT_XOR);
            end
        end else if (wr_en) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: captures the addressed line and holds it between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 16'h0000;
        end else if (rd_en) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder: accepts line reads/writes on the level-handshake bus,
// waits LATENCY cycles, commits and pulses bus_done for one cycle.
module bus_memory_responder
    import mem_bus_pkg::*;
#(
    parameter int                    LATENCY  = 4,
    parameter logic [BUS_DATA_W-1:0] INIT_XOR = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_rd,
    input  logic                  bus_wr,
    input  logic [BUS_ADDR_W-1:0] bus_addr,
    input  logic [BUS_DATA_W-1:0] bus_wdata,
    output logic [BUS_DATA_W-1:0] bus_rdata,
    output logic                  bus_done,
    output logic                  busy,
    output logic                  protocol_err
);

    // The counter holds the BUSY cycles still to spend after the current one,
    // so LATENCY cycles are spent in BUSY before DONE.
    localparam logic [3:0] LAT_LOAD_C = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    resp_state_t           state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic [BUS_ADDR_W-1:0] addr_r;
    logic [BUS_DATA_W-1:0] wdata_r;
    logic                  op_wr_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  perr_r;

    logic                  rd_req_s, wr_req_s, held_s;
    logic                  accept_s, commit_s, commit_wr_s;
    logic [BUS_ADDR_W-1:0] commit_addr_s;
    logic [BUS_DATA_W-1:0] commit_wdata_s;

    // Request qualification: only a solid 1 is a request; floating or unknown is idle
    always_comb begin
        rd_req_s = 1'b0;
        wr_req_s = 1'b0;
        held_s   = 1'b0;
        if (bus_rd == 1'b1) begin
            rd_req_s = 1'b1;
        end else begin
            rd_req_s = 1'b0;
        end
        if (bus_wr == 1'b1) begin
            wr_req_s = 1'b1;
        end else begin
            wr_req_s = 1'b0;
        end
        if (op_wr_r) begin
            held_s = wr_req_s;
        end else begin
            held_s = rd_req_s;
        end
    end

    // Next-state, counter and commit decode
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        accept_s       = 1'b0;
        commit_s       = 1'b0;
        commit_wr_s    = op_wr_r;
        commit_addr_s  = addr_r;
        commit_wdata_s = wdata_r;
        case (state_r)
            R_IDLE: begin
                // Zero-latency commits on the accept edge, so use the live bus
                commit_wr_s    = wr_req_s;
                commit_addr_s  = bus_addr;
                commit_wdata_s = bus_wdata;
                if (rd_req_s || wr_req_s) begin
                    accept_s = 1'b1;
                    cnt_s    = LAT_LOAD_C;
                    if (LATENCY == 0) begin
                        state_s  = R_DONE;
                        commit_s = 1'b1;
                    end else begin
                        state_s = R_BUSY;
                    end
                end else begin
                    state_s = R_IDLE;
                end
            end
            R_BUSY: begin
                if (!held_s) begin
                    state_s = R_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s  = R_DONE;
                    commit_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            R_DONE: begin
                state_s = R_IDLE;
            end
            default: begin
                state_s = R_IDLE;
            end
        endcase
    end

    // State, counter and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= R_IDLE;
            cnt_r   <= 4'd0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= commit_s;
            busy_r  <= (state_s != R_IDLE);
            if (accept_s && rd_req_s && wr_req_s) begin
                perr_r <= 1'b1;
            end
        end
    end

    // Transaction capture at acceptance; write wins when both requests are high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r  <= 5'd0;
            wdata_r <= 16'h0000;
            op_wr_r <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= bus_addr;
            wdata_r <= bus_wdata;
            op_wr_r <= wr_req_s;
        end
    end

    mem_array_32x16 #(
        .INIT_XOR (INIT_XOR)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .wr_en (commit_s & commit_wr_s),
        .rd_en (commit_s & ~commit_wr_s),
        .addr  (commit_addr_s),
        .wdata (commit_wdata_s),
        .rdata (bus_rdata)
    );

    assign bus_done     = done_r;
    assign busy         = busy_r;
    assign protocol_err = perr_r;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench for bus_memory_responder (LATENCY=4 main instance,
// LATENCY=0 second instance).
module tb_bus_memory_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_rd, bus_wr;
    logic [4:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_done, busy, protocol_err;

    logic        rd0, wr0;
    logic [4:0]  addr0;
    logic [15:0] wdata0;
    logic [15:0] rdata0;
    logic        done0, busy0, perr0;

    typedef struct {
        logic        chk;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bus_memory_responder #(.LATENCY(4), .INIT_XOR(16'h0000)) dut (
        .clk(clk), .reset(reset), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_done(bus_done), .busy(busy), .protocol_err(protocol_err)
    );

    bus_memory_responder #(.LATENCY(0), .INIT_XOR(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .bus_rd(rd0), .bus_wr(wr0),
        .bus_addr(addr0), .bus_wdata(wdata0), .bus_rdata(rdata0),
        .bus_done(done0), .busy(busy0), .protocol_err(perr0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every bus_done pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (bus_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.at));
                if (e.chk) check("rdata", {16'h0000, bus_rdata}, {16'h0000, e.data});
            end
        end
    end

    task automatic start(input logic wr, input logic rd, input logic [4:0] a,
                         input logic [15:0] wd, input logic chk, input logic [15:0] ed);
        @(posedge clk); #1;
        bus_wr = wr; bus_rd = rd; bus_addr = a; bus_wdata = wd;
        exp_q.push_back('{chk, ed, cyc + 5});
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_done !== 1'b1 && n < 40);
        if (bus_done !== 1'b1) fail_now("done_timeout");
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus_wr = 1'b0; bus_rd = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic rd, input logic [4:0] a,
                       input logic [15:0] wd, input logic chk, input logic [15:0] ed);
        start(wr, rd, a, wd, chk, ed);
        wait_done();
        idle();
    endtask

    // Request held two cycles then floated: must abort with no done
    task automatic abort_txn(input logic is_wr, input logic [4:0] a);
        int c;
        @(posedge clk); #1;
        bus_addr = a; bus_wdata = 16'hDEAD;
        if (is_wr) bus_wr = 1'b1; else bus_rd = 1'b1;
        c = cyc;
        repeat (2) @(posedge clk);
        #1;
        if (is_wr) bus_wr = 1'bz; else bus_rd = 1'bz;
        @(negedge clk);
        check("abort_busy_hold", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("abort_busy_drop", {31'd0, busy}, 32'd0);
        check("abort_cycle", 32'(cyc), 32'(c + 3));
        repeat (6) @(negedge clk);
        bus_wr = 1'b0; bus_rd = 1'b0;
    endtask

    initial begin
        int c0;
        reset = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = 5'd0; bus_wdata = 16'h0000;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 5'd0; wdata0 = 16'h0000;
        #1;
        check("rst_done",  {31'd0, bus_done},     32'd0);
        check("rst_busy",  {31'd0, busy},         32'd0);
        check("rst_perr",  {31'd0, protocol_err}, 32'd0);
        check("rst_rdata", {16'h0000, bus_rdata}, 32'h0000_0000);
        check("rst_busy0", {31'd0, busy0},        32'd0);
        check("rst_perr0", {31'd0, perr0},        32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Read addr 3 with busy profile: busy in cycles c0+1..c0+5, done at c0+5
        start(1'b0, 1'b1, 5'd3, 16'h0000, 1'b1, 16'h0303);
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy_profile", {31'd0, busy},
                  {31'd0, (cyc >= c0 + 1) && (cyc <= c0 + 5)});
        end
        idle();
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);

        // Write then read back, plus an untouched neighbour
        txn(1'b1, 1'b0, 5'd9,  16'hBEEF, 1'b0, 16'h0000);
        txn(1'b0, 1'b1, 5'd9,  16'h0000, 1'b1, 16'hBEEF);
        txn(1'b0, 1'b1, 5'd10, 16'h0000, 1'b1, 16'h0A0A);

        // Write-back then fill, back to back
        start(1'b1, 1'b0, 5'h0A, 16'h1234, 1'b0, 16'h0000);
        wait_done();
        start(1'b0, 1'b1, 5'h12, 16'h0000, 1'b1, 16'h1212);
        wait_done();
        idle();
        txn(1'b0, 1'b1, 5'h0A, 16'h0000, 1'b1, 16'h1234);

        // Abort by floating the request; array must be untouched
        abort_txn(1'b1, 5'd7);
        abort_txn(1'b0, 5'd7);
        txn(1'b0, 1'b1, 5'd7, 16'h0000, 1'b1, 16'h0707);

        // Both requests high: write wins, sticky protocol error
        check("perr_before", {31'd0, protocol_err}, 32'd0);
        txn(1'b1, 1'b1, 5'd4, 16'h00FF, 1'b0, 16'h0000);
        check("perr_set", {31'd0, protocol_err}, 32'd1);
        txn(1'b0, 1'b1, 5'd4, 16'h0000, 1'b1, 16'h00FF);
        check("perr_sticky", {31'd0, protocol_err}, 32'd1);

        // Zero-latency instance: done in the cycle after the request
        @(posedge clk); #1;
        rd0 = 1'b1; addr0 = 5'd5;
        @(negedge clk);
        check("lat0_done_c0", {31'd0, done0}, 32'd0);
        @(posedge clk); #1;
        rd0 = 1'b0;
        @(negedge clk);
        check("lat0_done_c1", {31'd0, done0}, 32'd1);
        check("lat0_rdata", {16'h0000, rdata0}, 32'h0000_0505);
        @(negedge clk);
        check("lat0_done_c2", {31'd0, done0}, 32'd0);

        // Reset in the middle of a write to addr 2
        @(posedge clk); #1;
        bus_wr = 1'b1; bus_addr = 5'd2; bus_wdata = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus_wr = 1'b0;
        @(negedge clk);
        check("mid_rst_done",  {31'd0, bus_done},     32'd0);
        check("mid_rst_busy",  {31'd0, busy},         32'd0);
        check("mid_rst_perr",  {31'd0, protocol_err}, 32'd0);
        check("mid_rst_rdata", {16'h0000, bus_rdata}, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        txn(1'b0, 1'b1, 5'd2, 16'h0000, 1'b1, 16'h0202);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
